// File: rtl/tt_arb_pkg.sv
// Shared constants and types for the four-requester round-robin arbiter.
package tt_arb_pkg;

  localparam int NUM_REQ = 4;

  localparam logic [7:0] UIO_OE_VAL = 8'hF0;

  // Arbiter control states; encodings are fixed so debug taps read consistently.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first asserted request searching upward from last+1 (mod 4).
module rr_pick
  import tt_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] pick,
  output logic       valid
);

  // Scan from the farthest candidate back to last+1 so the nearest match wins.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req[last + 2'(i)]) begin
        pick  = last + 2'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tt_um_rr_arbiter.sv
// Round-robin arbiter sharing the inverting output datapath among four requesters.
// Handshake: a requester holds req high as long as it wants the datapath; the
// arbiter answers with a one-hot grant one edge later and keeps it until done,
// req drop, or the hold limit. Grants are always separated by one dead GAP cycle.
module tt_um_rr_arbiter
  import tt_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  logic [3:0] req;
  logic       done;
  logic       clr_to;

  state_t             state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               to_q, to_d;
  logic [3:0]         data_q, data_d;

  logic [1:0] pick;
  logic       pick_valid;
  logic       hold_limit;
  logic       normal_release;
  logic       timeout_hit;
  logic [3:0] grant;
  logic       unused_ok;

  assign req    = ui_in[3:0];
  assign done   = ui_in[4];
  assign clr_to = ui_in[5];

  // Pins that carry no function on this design.
  assign unused_ok = ^{ena, ui_in[7:6], uio_in[7:4]};

  rr_pick u_pick (
    .req   (req),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  // A release by done or req drop wins over the limit, so only a pure limit exit flags.
  assign hold_limit     = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign normal_release = done || !req[owner_q];
  assign timeout_hit    = (state_q == ST_GRANT) && hold_limit && !normal_release;

  // State and datapath registers; reset drops the grant without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      data_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      data_q  <= data_d;
    end
  end

  // Next-state and next-datapath values.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    data_d  = 4'h0;
    case (state_q)
      ST_IDLE:  if (pick_valid) state_d = ST_GRANT;
      ST_GRANT: if (normal_release || hold_limit) state_d = ST_GAP;
      ST_GAP:   state_d = pick_valid ? ST_GRANT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (state_q != ST_GRANT && state_d == ST_GRANT) begin
      owner_d = pick;
      cnt_d   = '0;
    end
    if (state_q == ST_GRANT) begin
      if (state_d == ST_GRANT) begin
        cnt_d  = cnt_q + CNT_W'(1);
        data_d = ~uio_in[3:0];
      end else begin
        last_d = owner_q;
      end
    end

    // Set beats clear when both happen on the same edge.
    if (timeout_hit)  to_d = 1'b1;
    else if (clr_to)  to_d = 1'b0;
    else              to_d = to_q;
  end

  // Output decode from the registered state.
  always_comb begin
    grant = 4'b0000;
    if (state_q == ST_GRANT) grant = 4'b0001 << owner_q;
    uio_out = {grant, 4'b0000};
    uio_oe  = UIO_OE_VAL;
    uo_out  = {to_q, (state_q == ST_GRANT), owner_q, data_q};
  end

endmodule

// File: tb/tb_tt_um_rr_arbiter.sv
// Bench for the round-robin arbiter: vector table, corner sequences, random vs model.
module tb_tt_um_rr_arbiter;

  localparam int MAX_HOLD = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 granted, 2 dead cycle; held counts grant cycles.
  int         m_phase;
  int         m_owner;
  int         m_last;
  int         m_held;
  bit         m_to;
  logic [3:0] m_data;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic       clr;
    logic [3:0] din;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;

  vec_t tbl[18];

  tt_um_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .uo_out  (uo_out)
  );

  // Clock and reset
  always #5 clk = ~clk;

  function automatic int model_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_owner = 0;
    m_last  = 3;
    m_held  = 0;
    m_to    = 1'b0;
    m_data  = 4'h0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic dn, input logic clr,
                            input logic [3:0] din);
    bit tmo;
    tmo = 1'b0;
    m_data = 4'h0;
    case (m_phase)
      0: begin
        if (r != 4'h0) begin
          m_owner = model_pick(r, m_last);
          m_phase = 1;
          m_held  = 1;
        end
      end
      1: begin
        if (dn || !r[m_owner] || m_held == MAX_HOLD) begin
          tmo     = (m_held == MAX_HOLD) && !dn && r[m_owner];
          m_phase = 2;
          m_last  = m_owner;
        end else begin
          m_held = m_held + 1;
          m_data = ~din;
        end
      end
      default: begin
        if (r != 4'h0) begin
          m_owner = model_pick(r, m_last);
          m_phase = 1;
          m_held  = 1;
        end else begin
          m_phase = 0;
        end
      end
    endcase
    if (tmo) m_to = 1'b1;
    else if (clr) m_to = 1'b0;
  endtask

  function automatic logic [7:0] model_uo();
    return {m_to, (m_phase == 1), 2'(m_owner), m_data};
  endfunction

  function automatic logic [7:0] model_uio();
    logic [3:0] g;
    g = 4'h0;
    if (m_phase == 1) g = 4'b0001 << m_owner;
    return {g, 4'h0};
  endfunction

  // Scoreboard compare
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Driver: present inputs, take one active edge, then settle 1 time unit.
  task automatic cyc(input logic [3:0] r, input logic dn, input logic clr,
                     input logic [3:0] din);
    ui_in  = {2'($urandom_range(0, 3)), clr, dn, r};
    uio_in = {4'($urandom_range(0, 15)), din};
    @(posedge clk);
    model_step(r, dn, clr, din);
    #1;
  endtask

  task automatic do_reset();
    ui_in  = 8'h00;
    uio_in = 8'h00;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_uo", uo_out, 8'h00);
    chk("reset_uio", uio_out, 8'h00);
    chk("reset_oe", uio_oe, 8'hF0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [3:0] rr;
    model_reset();

    // Vector table: fairness rotation, data path, req-drop release, idle done.
    tbl[0]  = '{4'hF, 1'b0, 1'b0, 4'h0, 8'h40, 8'h10};
    tbl[1]  = '{4'hF, 1'b1, 1'b0, 4'h0, 8'h00, 8'h00};
    tbl[2]  = '{4'hF, 1'b0, 1'b0, 4'h0, 8'h50, 8'h20};
    tbl[3]  = '{4'hF, 1'b1, 1'b0, 4'h0, 8'h10, 8'h00};
    tbl[4]  = '{4'hF, 1'b0, 1'b0, 4'h0, 8'h60, 8'h40};
    tbl[5]  = '{4'hF, 1'b1, 1'b0, 4'h0, 8'h20, 8'h00};
    tbl[6]  = '{4'hF, 1'b0, 1'b0, 4'h0, 8'h70, 8'h80};
    tbl[7]  = '{4'hF, 1'b1, 1'b0, 4'h0, 8'h30, 8'h00};
    tbl[8]  = '{4'hF, 1'b0, 1'b0, 4'h0, 8'h40, 8'h10};
    tbl[9]  = '{4'hF, 1'b0, 1'b0, 4'hA, 8'h45, 8'h10};
    tbl[10] = '{4'h0, 1'b0, 1'b0, 4'hA, 8'h00, 8'h00};
    tbl[11] = '{4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00};
    tbl[12] = '{4'h4, 1'b0, 1'b0, 4'h3, 8'h60, 8'h40};
    tbl[13] = '{4'h4, 1'b0, 1'b0, 4'h3, 8'h6C, 8'h40};
    tbl[14] = '{4'h4, 1'b0, 1'b0, 4'h9, 8'h66, 8'h40};
    tbl[15] = '{4'h0, 1'b0, 1'b0, 4'h0, 8'h20, 8'h00};
    tbl[16] = '{4'h0, 1'b0, 1'b0, 4'h0, 8'h20, 8'h00};
    tbl[17] = '{4'h1, 1'b1, 1'b0, 4'h0, 8'h40, 8'h10};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].req, tbl[i].done, tbl[i].clr, tbl[i].din);
      chk($sformatf("tbl%0d_uo", i), uo_out, tbl[i].exp_uo);
      chk($sformatf("tbl%0d_uio", i), uio_out, tbl[i].exp_uio);
    end

    // Single requester held through the hold limit, then flag clear behaviour.
    do_reset();
    cyc(4'h1, 1'b0, 1'b0, 4'hA);
    chk("to_first_grant_uo", uo_out, 8'h40);
    chk("to_first_grant_uio", uio_out, 8'h10);
    cyc(4'h1, 1'b0, 1'b0, 4'hA);
    chk("to_data", uo_out, 8'h45);
    repeat (13) cyc(4'h1, 1'b0, 1'b0, 4'hA);
    chk("to_last_cycle", uo_out, 8'h45);
    cyc(4'h1, 1'b0, 1'b0, 4'hA);
    chk("to_gap_uo", uo_out, 8'h80);
    chk("to_gap_uio", uio_out, 8'h00);
    cyc(4'h1, 1'b0, 1'b0, 4'hA);
    chk("to_regrant_uo", uo_out, 8'hC0);
    chk("to_regrant_uio", uio_out, 8'h10);
    cyc(4'h1, 1'b0, 1'b1, 4'hA);
    chk("clr_clears", uo_out, 8'h45);
    repeat (13) cyc(4'h1, 1'b0, 1'b0, 4'hA);
    cyc(4'h1, 1'b0, 1'b1, 4'hA);
    chk("clr_vs_timeout", uo_out, 8'h80);

    // done arriving on the final permitted grant cycle is a normal release.
    do_reset();
    cyc(4'h1, 1'b0, 1'b0, 4'h7);
    repeat (14) cyc(4'h1, 1'b0, 1'b0, 4'h7);
    chk("limit_still_granted", uio_out, 8'h10);
    cyc(4'h1, 1'b1, 1'b0, 4'h7);
    chk("done_at_limit_uo", uo_out, 8'h00);
    chk("done_at_limit_uio", uio_out, 8'h00);

    // Asynchronous reset while requester 3 owns the datapath.
    do_reset();
    cyc(4'h8, 1'b0, 1'b0, 4'h5);
    chk("grant3_uo", uo_out, 8'h70);
    chk("grant3_uio", uio_out, 8'h80);
    cyc(4'h8, 1'b0, 1'b0, 4'h5);
    chk("grant3_data", uo_out, 8'h7A);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_uo", uo_out, 8'h00);
    chk("async_rst_uio", uio_out, 8'h00);
    chk("async_rst_oe", uio_oe, 8'hF0);
    #2;
    rst_n = 1'b1;
    model_reset();
    cyc(4'h8, 1'b0, 1'b0, 4'h5);
    chk("after_rst_uo", uo_out, 8'h70);
    chk("after_rst_uio", uio_out, 8'h80);

    // Random traffic against the model; even blocks hold requests long to hit timeouts.
    do_reset();
    rr = 4'($urandom_range(0, 15));
    for (int blk = 0; blk < 6; blk++) begin
      for (int c = 0; c < 100; c++) begin
        if ($urandom_range(0, (blk % 2 == 0) ? 29 : 3) == 0) rr = 4'($urandom_range(0, 15));
        cyc(rr, ($urandom_range(0, 11) == 0), ($urandom_range(0, 19) == 0),
            4'($urandom_range(0, 15)));
        chk("rand_uo", uo_out, model_uo());
        chk("rand_uio", uio_out, model_uio());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tt_um_rr_arbiter.md
Name: tt_um_rr_arbiter

Overview:
- Four-requester round-robin arbiter that shares the project's single inverting output datapath (uo_out = ~data) between external requesters.
- Requesters raise request pins. The arbiter grants one at a time, enforces a maximum hold time, and drives the granted requester's inverted data nibble onto uo_out.
- Sits as the top-level project module on the standard user-project pin interface.

Parameters:
- MAX_HOLD, 15, maximum GRANT cycles before forced release; legal range 1..(2^CNT_W - 1).
- CNT_W, 4, width of the hold counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  always 1 when powered; ignored.
- ui_in  input  8  [3:0] req (one per requester); [4] done (owner release); [5] clr_to (clears timeout flag); [7:6] unused.
- uio_in  input  8  [3:0] data nibble from the current owner; [7:4] unused.
- uio_out  output  8  [7:4] grant one-hot; [3:0] constant 0.
- uio_oe  output  8  constant 8'hF0.
- uo_out  output  8  [3:0] registered ~data; [5:4] owner index; [6] busy; [7] sticky timeout flag.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE, grant=0, owner=0, uo_out=8'h00, hold count=0, timeout flag=0.
  - last-owner pointer=3, so requester 0 has top priority first.
- Reset mid-GRANT drops grant and clears outputs immediately, without waiting for a clock edge.
- States: IDLE, GRANT, GAP.
- Round-robin pick:
  - Search starts at last+1 mod 4 and takes the first asserted req.
  - Pure combinational function of req[3:0] and last.
- IDLE:
  - Any req at edge k → GRANT.
  - grant[pick] set, owner=pick, busy=1, count=0, all visible after edge k. Request-to-grant latency is 1 cycle.
- GRANT, evaluated at each edge:
  - uo_out[3:0] <= ~uio_in[3:0]; data lags the input by 1 cycle.
  - count increments.
  - Exit to GAP when done=1, or req[owner]=0, or count==MAX_HOLD-1, so the grant lasts at most MAX_HOLD cycles.
  - Timeout exit, meaning neither done nor req drop in the same cycle, sets the timeout flag. done or req-drop coinciding with the limit counts as a normal release: no flag.
- GAP, exactly 1 cycle:
  - grant=0, busy=0, uo_out[3:0]=0, last=owner.
  - At the next edge: GRANT to the new pick if any req, else IDLE.
  - Back-to-back owners are therefore separated by one dead cycle.
- Requests arriving during GRANT or GAP are not lost as long as they are still held at the arbitration edge. Req pins are level-sensitive and are not latched.
- A requester that times out and keeps req high is re-granted only after all other active requesters (rotation).
- Timeout flag:
  - Sticky.
  - Cleared at an edge when clr_to=1, unless a timeout occurs in the same cycle; set has priority.
- owner field:
  - Holds its value in IDLE and GAP.
  - Updated only on entry to GRANT.
- done outside GRANT is ignored.
- Only one grant bit is ever set; grant=0 in IDLE and GAP.

Decomposition:
- Package tt_arb_pkg holds:
  - NUM_REQ=4.
  - State encoding constants ST_IDLE=2'd0, ST_GRANT=2'd1, ST_GAP=2'd2.
  - UIO_OE_VAL=8'hF0.
- Sub-module rr_pick (combinational):
  - Inputs: req[3:0], last[1:0].
  - Outputs: pick[1:0], valid.
  - Instantiated once; unit-testable on its own.

Test Plan:
- Single requester, hold through timeout:
  - Stimulus: after reset, req=4'b0001, uio_in[3:0]=4'hA, held.
  - Response: one edge later grant=4'b0001 and owner=0; the next edge uo_out[3:0]=4'h5.
  - After 15 grant cycles: GAP with grant=0, uo_out[7]=1. After GAP: re-grant to 0.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held, done pulsed 1 cycle after each grant.
  - Response: grant order 0,1,2,3,0; one GAP cycle between each.
- Release by req drop:
  - Stimulus: requester 2 granted, req[2] drops after 3 cycles.
  - Response: GAP on the next edge, timeout flag stays 0, owner stays 2 in GAP and IDLE.
- done coincident with limit:
  - Stimulus: done=1 on the 15th grant cycle.
  - Response: GAP entered, uo_out[7] remains 0.
  - Separately: clr_to=1 with the flag set clears it; clr_to=1 coinciding with a timeout leaves it at 1.
- Async reset mid-grant:
  - Stimulus: rst_n low between edges during GRANT with owner=3.
  - Response: uo_out=0 and uio_out=0 immediately, uio_oe=8'hF0.
  - After release with req=4'b1000: grant=4'b1000 after 1 edge.
